// File: rtl/dither_pkg.sv
// dither_pkg
// Shared definitions for the dithering accelerator.
// Contents:
//   - image geometry constants;
//   - the pixel loader FSM state type;
//   - a helper that sizes FIFO pointers.
package dither_pkg;

    localparam int IMG_X             = 16;
    localparam int IMG_Y             = 16;
    localparam int IMG_SIZE          = IMG_X * IMG_Y;
    localparam int IMG_ADDR_W        = $clog2(IMG_SIZE);
    localparam int PIXEL_W           = 8;
    localparam int LOADER_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } loader_state_t;

    // Pointers carry one extra wrap bit above the index.
    // With that bit, full and empty can be told apart
    // without a separate occupancy register.
    function automatic int fifoPtrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// loader_fifo
// Synchronous first-word fall-through FIFO. It absorbs SRAM backpressure
// between the pixel byte interface and the image SRAM write port.
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset.
//   i_clear        : synchronous flush of both pointers.
//   i_push, i_data : write an entry; ignored when full.
//   i_pop          : discard the head entry; ignored when empty.
//   o_data         : current head entry, valid whenever o_empty is low.
//   o_full, o_empty, o_count : occupancy status.
module loader_fifo
    import dither_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = fifoPtrWidth(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W-1:0] o_count
);

    localparam int IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    // The FIFO is full when the indices match but the wrap bits differ.
    // It is empty when the whole pointers are equal.
    assign o_full   = (r_wrPtr[IDX_W] != r_rdPtr[IDX_W]) &&
                      (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_count  = r_wrPtr - r_rdPtr;
    assign o_data   = r_mem[r_rdPtr[IDX_W-1:0]];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Pointer update. A flush wins over any push or pop in the same cycle,
    // so a new frame always starts from an empty buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
        end
    end

    // Storage has no reset. An entry is only ever read after it has been
    // written, because the read side is gated by o_empty.
    always_ff @(posedge i_clk) begin
        if (w_doPush) r_mem[r_wrPtr[IDX_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader
// Ingest stage of the dithering accelerator.
// Operation:
//   - Arms on MCU_TX_RDY.
//   - Accepts one greyscale byte per byte_valid cycle.
//   - Buffers the bytes in a small FIFO.
//   - Writes them to image SRAM addresses 0..IMAGE_SIZE-1 in arrival order.
//   - Pulses load_done once the last pixel has been committed.
// Ports:
//   MAX10_CLK1_50, KEY0 : clock, asynchronous active-low reset.
//   MCU_TX_RDY          : start request, sampled only while idle.
//   external_SPI_data, byte_valid : incoming pixel stream.
//   mem_ready           : SRAM accepts a write this cycle.
//   sram_addr, sram_wdata, sram_we : SRAM write port.
//   busy, load_done, overflow, pixel_count : status.
module spi_pixel_loader
    import dither_pkg::*;
#(
    parameter int IMAGEX           = IMG_X,
    parameter int IMAGEY           = IMG_Y,
    parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int RGB_SIZE         = PIXEL_W,
    parameter int FIFO_DEPTH       = LOADER_FIFO_DEPTH
) (
    input  logic                        MAX10_CLK1_50,
    input  logic                        KEY0,
    input  logic                        MCU_TX_RDY,
    input  logic [RGB_SIZE-1:0]         external_SPI_data,
    input  logic                        byte_valid,
    input  logic                        mem_ready,
    output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
    output logic [RGB_SIZE-1:0]         sram_wdata,
    output logic                        sram_we,
    output logic                        busy,
    output logic                        load_done,
    output logic                        overflow,
    output logic [IMAGE_ADDR_WIDTH:0]   pixel_count
);

    localparam int                CNT_W     = IMAGE_ADDR_WIDTH + 1;
    localparam int                PTR_W     = fifoPtrWidth(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  FRAME_LEN = CNT_W'(IMAGE_SIZE);
    localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(IMAGE_SIZE - 1);

    loader_state_t       r_state;
    loader_state_t       w_nextState;
    logic [CNT_W-1:0]    r_pixelCount;
    logic [CNT_W-1:0]    r_wrCnt;
    logic                r_overflow;

    logic                w_arm;
    logic                w_accepting;
    logic                w_push;
    logic                w_drop;
    logic                w_writing;
    logic                w_pop;
    logic                w_lastCommit;
    logic                w_fifoFull;
    logic                w_fifoEmpty;
    logic [PTR_W-1:0]    w_fifoCount;
    logic [RGB_SIZE-1:0] w_fifoHead;

    // Pushes stop once a full frame has been accepted, even if the MCU keeps
    // streaming. A write is committed on any cycle where the head is offered
    // and the SRAM accepts it.
    assign w_arm        = (r_state == IDLE) && MCU_TX_RDY;
    assign w_accepting  = (r_state == LOAD) && (r_pixelCount != FRAME_LEN);
    assign w_push       = w_accepting && byte_valid && !w_fifoFull;
    assign w_drop       = w_accepting && byte_valid && w_fifoFull;
    assign w_writing    = ((r_state == LOAD) || (r_state == DRAIN)) && !w_fifoEmpty;
    assign w_pop        = w_writing && mem_ready;
    // The final pixel is, by construction, the only entry left when it commits.
    assign w_lastCommit = w_pop && (r_wrCnt == LAST_ADDR) && (w_fifoCount == PTR_W'(1));

    loader_fifo #(
        .WIDTH (RGB_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (MAX10_CLK1_50),
        .i_rst_n (KEY0),
        .i_clear (w_arm),
        .i_push  (w_push),
        .i_data  (external_SPI_data),
        .i_pop   (w_pop),
        .o_data  (w_fifoHead),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    // State register.
    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state logic.
    // When the last byte drains while LOAD is still active, the FSM goes
    // straight to DONE. That keeps load_done exactly one cycle behind the
    // final write.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (MCU_TX_RDY) w_nextState = LOAD;
            LOAD:  if (r_pixelCount == FRAME_LEN)
                       w_nextState = w_lastCommit ? DONE : DRAIN;
            DRAIN: if (w_lastCommit) w_nextState = DONE;
            DONE:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Frame counters and the sticky overflow flag.
    // Arming clears them. overflow then survives DONE and IDLE, so the MCU
    // can read it back after the frame.
    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_pixelCount <= '0;
            r_wrCnt      <= '0;
            r_overflow   <= 1'b0;
        end else if (w_arm) begin
            r_pixelCount <= '0;
            r_wrCnt      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) r_pixelCount <= r_pixelCount + CNT_W'(1);
            if (w_drop) r_overflow   <= 1'b1;
            if (w_pop)  r_wrCnt      <= r_wrCnt + CNT_W'(1);
        end
    end

    // sram_addr is the low bits of the write counter. After a complete frame
    // it therefore reads back as 0.
    assign sram_we     = w_writing;
    assign sram_wdata  = w_writing ? w_fifoHead : '0;
    assign sram_addr   = r_wrCnt[IMAGE_ADDR_WIDTH-1:0];
    assign busy        = (r_state == LOAD) || (r_state == DRAIN);
    assign load_done   = (r_state == DONE);
    assign overflow    = r_overflow;
    assign pixel_count = r_pixelCount;

endmodule

// File: doc/spi_pixel_loader.md
Name: spi_pixel_loader

Overview:
- Upstream ingest stage of the dithering accelerator, sitting between the MCU byte interface and the image SRAM that the Floyd-Steinberg core reads.
- Arms on an MCU_TX_RDY pulse and accepts one greyscale pixel byte per valid cycle.
- Buffers each byte through a small FIFO to absorb SRAM backpressure, then writes it to sequential SRAM addresses 0..IMAGE_SIZE-1.
- Pulses load_done once the last pixel has been committed, so the dither core can start.

Parameters:
- IMAGEX, 16, image width in pixels.
- IMAGEY, 16, image height in pixels.
- IMAGE_SIZE, IMAGEX*IMAGEY, pixels per frame.
- IMAGE_ADDR_WIDTH, $clog2(IMAGE_SIZE), SRAM address width.
- RGB_SIZE, 8, pixel width in bits.
- FIFO_DEPTH, 4, skid FIFO entries; must be a power of 2 and at least 2.

Ports:
- MAX10_CLK1_50 input 1: system clock; all logic on rising edge.
- KEY0 input 1: reset, asynchronous assert, active-low.
- MCU_TX_RDY input 1: start request; sampled only in IDLE.
- external_SPI_data input RGB_SIZE: incoming pixel byte.
- byte_valid input 1: external_SPI_data is valid this cycle (TopLevel ties it high for a streaming MCU).
- mem_ready input 1: SRAM accepts a write this cycle.
- sram_addr output IMAGE_ADDR_WIDTH: write address.
- sram_wdata output RGB_SIZE: write data.
- sram_we output 1: write strobe; a write completes on a cycle where sram_we and mem_ready are both 1.
- busy output 1: high in LOAD and DRAIN.
- load_done output 1: one-cycle pulse when the frame is complete.
- overflow output 1: sticky flag, a byte was dropped because the FIFO was full.
- pixel_count output IMAGE_ADDR_WIDTH+1: bytes accepted into the FIFO this frame.

Behaviour:
- Reset values (KEY0=0, applied immediately):
  - state=IDLE; FIFO empty.
  - sram_addr=0, sram_wdata=0, sram_we=0.
  - busy=0, load_done=0, overflow=0, pixel_count=0.
- Reset mid-frame aborts the frame. No load_done is produced. Re-arming requires a fresh MCU_TX_RDY pulse.
- IDLE:
  - MCU_TX_RDY=1 moves to LOAD on the next edge and clears pixel_count, overflow, the write address and the FIFO pointers.
  - Bytes presented while in IDLE are ignored, including the byte on the same cycle MCU_TX_RDY is high.
- LOAD:
  - Each cycle with byte_valid=1 and FIFO not full pushes external_SPI_data and increments pixel_count.
  - byte_valid=1 with FIFO full drops the byte, sets overflow, and leaves pixel_count unchanged.
  - When pixel_count reaches IMAGE_SIZE, move to DRAIN. Further bytes are ignored.
  - MCU_TX_RDY is ignored while in LOAD.
- Write side (LOAD and DRAIN):
  - sram_we = FIFO not empty; sram_wdata = FIFO head (first-word fall-through); sram_addr = write counter.
  - On sram_we & mem_ready: pop the FIFO and increment the write counter.
  - A simultaneous push and pop is legal and leaves the occupancy unchanged.
  - Data must be written in exact arrival order, with no gaps in address.
- DRAIN: when the write counter reaches IMAGE_SIZE (the last write commits), go to DONE.
- DONE:
  - load_done=1 for exactly one cycle, busy=0, then return to IDLE.
  - sram_addr holds the wrapped value 0.
  - overflow remains readable until the next arm.
- Latency: a byte accepted at edge N can appear on sram_we/sram_wdata at cycle N+1 at the earliest (registered FIFO).
- Throughput: 1 byte/cycle sustained when mem_ready is held high. The FIFO never fills in that case, so overflow stays 0.
- Width rules:
  - The write counter is IMAGE_ADDR_WIDTH+1 bits internally, so IMAGE_SIZE is detectable. sram_addr is its low bits.
  - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, with full/empty decided by the MSB compare.
- A frame shorter than IMAGE_SIZE (the MCU stops sending) stays in LOAD indefinitely. There is no timeout; reset is the recovery path.

Decomposition:
- Package dither_pkg holds:
  - loader_state_t enum {IDLE, LOAD, DRAIN, DONE};
  - the localparam helper for pointer width;
  - the shared image constants already used across the design.
- One sub-module, loader_fifo: a synchronous first-word fall-through FIFO parameterised by width and depth, with push/pop/full/empty/count.
- The top FSM and counters stay in spi_pixel_loader.

Test Plan:
- Reset and idle: KEY0 low, then high, no MCU_TX_RDY, byte_valid=1 with random data for 50 cycles -> sram_we never 1, busy=0, pixel_count=0.
- Full frame at line rate: 1-cycle MCU_TX_RDY pulse, then 256 bytes 0x00..0xFF on consecutive cycles, mem_ready=1 ->
  - addresses 0..255 each written once with data equal to the address;
  - load_done pulses exactly once, 1 cycle after the write to 255;
  - overflow=0.
- Backpressure: the same frame with mem_ready toggling 1,0,1,0 and byte_valid every other cycle -> all 256 writes in order, overflow=0.
- Overflow: mem_ready=0 for 10 cycles while byte_valid=1 -> FIFO fills after 4 bytes; bytes 5..10 are dropped; overflow=1; pixel_count=4. Then release mem_ready and send the remaining 252 bytes -> frame completes and overflow stays 1.
- Reset mid-frame: assert KEY0 after 100 bytes -> all outputs return to reset values immediately; a following re-arm and full frame writes from address 0 correctly.
- Early bytes ignored: byte 0xAA on the MCU_TX_RDY cycle -> not written; the first write at address 0 carries the next byte.
